// File: rtl/ctrl_pipe_regs.sv
// Control-word pipeline registers (ID/EX, EX/MEM, MEM/WB). Also handles load-use stalls
// and flushes for branches/jumps that resolve in MEM.
module ctrl_pipe_regs #(
  parameter int REG_W     = 5,
  parameter int ALUOP_W   = 2,
  parameter bit HAZARD_EN = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               id_regdst,
  input  logic               id_alusrc,
  input  logic               id_memtoreg,
  input  logic               id_regwrite,
  input  logic               id_memread,
  input  logic               id_memwrite,
  input  logic               id_branch,
  input  logic               id_jump,
  input  logic [ALUOP_W-1:0] id_aluop,
  input  logic [REG_W-1:0]   id_rs,
  input  logic [REG_W-1:0]   id_rt,
  input  logic               flush,
  output logic               stall,
  output logic               ex_regdst,
  output logic               ex_alusrc,
  output logic [ALUOP_W-1:0] ex_aluop,
  output logic [REG_W-1:0]   ex_rt,
  output logic               mem_memread,
  output logic               mem_memwrite,
  output logic               mem_branch,
  output logic               mem_jump,
  output logic               wb_memtoreg,
  output logic               wb_regwrite
);

  logic ex_memtoreg, ex_regwrite, ex_memread, ex_memwrite, ex_branch, ex_jump;
  logic mem_memtoreg, mem_regwrite;
  logic hazard;

  // A load whose rt is $0 still counts as a hazard; the extra cycle is the price of not masking it.
  always_comb begin
    hazard = 1'b0;
    if (HAZARD_EN)
      hazard = ex_memread & ((ex_rt == id_rs) | (ex_rt == id_rt));
  end

  assign stall = hazard & ~flush & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_regdst    <= 1'b0;
      ex_alusrc    <= 1'b0;
      ex_aluop     <= '0;
      ex_rt        <= '0;
      ex_memtoreg  <= 1'b0;
      ex_regwrite  <= 1'b0;
      ex_memread   <= 1'b0;
      ex_memwrite  <= 1'b0;
      ex_branch    <= 1'b0;
      ex_jump      <= 1'b0;
      mem_memread  <= 1'b0;
      mem_memwrite <= 1'b0;
      mem_branch   <= 1'b0;
      mem_jump     <= 1'b0;
      mem_memtoreg <= 1'b0;
      mem_regwrite <= 1'b0;
      wb_memtoreg  <= 1'b0;
      wb_regwrite  <= 1'b0;
    end else begin
      // MEM/WB always advances, so the branch causing a flush still retires.
      wb_memtoreg <= mem_memtoreg;
      wb_regwrite <= mem_regwrite;
      if (flush) begin
        mem_memread  <= 1'b0;
        mem_memwrite <= 1'b0;
        mem_branch   <= 1'b0;
        mem_jump     <= 1'b0;
        mem_memtoreg <= 1'b0;
        mem_regwrite <= 1'b0;
      end else begin
        mem_memread  <= ex_memread;
        mem_memwrite <= ex_memwrite;
        mem_branch   <= ex_branch;
        mem_jump     <= ex_jump;
        mem_memtoreg <= ex_memtoreg;
        mem_regwrite <= ex_regwrite;
      end
      if (flush || stall) begin
        ex_regdst   <= 1'b0;
        ex_alusrc   <= 1'b0;
        ex_aluop    <= '0;
        ex_rt       <= '0;
        ex_memtoreg <= 1'b0;
        ex_regwrite <= 1'b0;
        ex_memread  <= 1'b0;
        ex_memwrite <= 1'b0;
        ex_branch   <= 1'b0;
        ex_jump     <= 1'b0;
      end else begin
        ex_regdst   <= id_regdst;
        ex_alusrc   <= id_alusrc;
        ex_aluop    <= id_aluop;
        ex_rt       <= id_rt;
        ex_memtoreg <= id_memtoreg;
        ex_regwrite <= id_regwrite;
        ex_memread  <= id_memread;
        ex_memwrite <= id_memwrite;
        ex_branch   <= id_branch;
        ex_jump     <= id_jump;
      end
    end
  end

endmodule
